counter_4bit: RTL and testbench
===============================

Name: counter_4bit

Overview:
- Synchronous binary counter, default width 4, clocked by iclk.
- Counts up by default. Supports enable, synchronous load, a direction select and a terminal-count flag.
- Used as a general-purpose event/cycle counter and as the standard reference for clock/reset bring-up. Output ocnt is free-running after reset release.

Parameters:
- WIDTH, 4, counter width in bits (legal range 2..32).
- RST_VAL, 0, value loaded into ocnt on reset (must fit in WIDTH bits).

Ports:
- iclk  input  1  clock; all state changes on the rising edge.
- irst  input  1  asynchronous, active-low reset.
- ien  input  1  count enable; 1 = count this cycle.
- iup  input  1  direction; 1 = up, 0 = down.
- iload  input  1  synchronous load strobe.
- idata  input  WIDTH  load value.
- ocnt  output  WIDTH  current count (registered).
- otc  output  1  terminal count (registered), see Behaviour.

Behaviour:
- Interface (already decided): one clock, iclk; reset irst is asynchronous and active-low.
- Reset:
  - irst=0 immediately forces ocnt=RST_VAL and otc=0, with no clock needed.
  - Reset is held for as long as irst=0.
  - Deassertion takes effect at the first rising edge with irst=1; the first count occurs on that edge if ien=1.
- Per-edge priority when irst=1:
  - iload=1: ocnt<=idata. This applies regardless of ien and iup.
  - else ien=1 and iup=1: ocnt<=ocnt+1, modulo 2^WIDTH. All-ones wraps to 0.
  - else ien=1 and iup=0: ocnt<=ocnt-1, modulo 2^WIDTH. 0 wraps to all-ones.
  - else: hold.
- Latency: ocnt reflects a load or count one edge after the controlling inputs are sampled. There is no combinational path from inputs to outputs.
- otc:
  - Registered. otc=1 during the cycle in which ocnt holds the terminal value for the current iup: all-ones when iup=1, 0 when iup=0.
  - Computed from the next ocnt value and the iup sampled on the same edge.
  - A loaded terminal value sets otc too.
- Reset mid-count: ocnt and otc clear asynchronously. Counting resumes from RST_VAL.
- ien=0 with iload=0 holds ocnt and otc unchanged.
- Width arithmetic is unsigned WIDTH-bit; overflow and underflow bits are discarded.

Optional Feature:
- Macro COUNTER_SATURATE_EN.
- Defined:
  - Up counting stops at all-ones and down counting stops at 0; no wrap.
  - otc behaves as above and stays 1 while saturated.
  - Load is unaffected.
- Not defined: modulo wrap as described in Behaviour.

Decomposition:
- Package counter_pkg:
  - localparam DEFAULT_WIDTH=4.
  - enum dir_e {DIR_DOWN=0, DIR_UP=1}.
  - function next_count(cnt, up, sat), which returns the next WIDTH-bit value.
- No sub-module is needed. The next-state function is kept in the package so it is shared with the verification model.

Test Plan:
- Reset: hold irst=0 for 100 time units (5 iclk periods, 20-unit period) with ien=1 -> ocnt=0, otc=0 throughout. Asynchronous clear occurs even between clock edges.
- Free-run up: release irst, ien=1, iup=1 -> ocnt goes 1,2,…,15,0,1 on successive edges; otc=1 only while ocnt=15.
  - Over 1900 time units (95 edges) final ocnt = 95 mod 16 = 15.
- Down/wrap: load 2, then iup=0 -> ocnt goes 2,1,0,15,14; otc=1 only while ocnt=0.
- Load priority: ocnt=7, iload=1, idata=12, ien=1 -> next ocnt=12, not 8. With ien=0 and iload=0, ocnt holds 12 for 3 edges.
- Mid-operation reset: at ocnt=9, pulse irst=0 for 5 time units between edges -> ocnt=0 at once, then 1 on the first edge after release.
- COUNTER_SATURATE_EN: count up from 14 for 4 edges -> ocnt goes 15,15,15,15 with otc=1. Without the macro -> ocnt goes 15,0,1,2.

Source files
------------

// File: rtl/counter_pkg.sv
// Shared types and next-count function for counter_4bit.
// The function is width-agnostic so the RTL and any verification model can share it.
package counter_pkg;

    localparam int DEFAULT_WIDTH = 4;

    typedef enum logic {
        DIR_DOWN = 1'b0,
        DIR_UP   = 1'b1
    } dir_e;

    // Operands are carried in 32 bits and masked down to the active width.
    function automatic logic [31:0] next_count(
        input logic [31:0] cnt,
        input dir_e        up,
        input logic        sat,
        input int unsigned width = DEFAULT_WIDTH
    );
        logic [31:0] max_val;
        logic [31:0] nxt;
        max_val = (width >= 32) ? 32'hFFFF_FFFF : ((32'd1 << width) - 32'd1);
        if (up == DIR_UP) begin
            if (sat && (cnt == max_val)) begin
                nxt = cnt;
            end else begin
                nxt = (cnt + 32'd1) & max_val;
            end
        end else begin
            if (sat && (cnt == 32'd0)) begin
                nxt = cnt;
            end else begin
                nxt = (cnt - 32'd1) & max_val;
            end
        end
        return nxt;
    endfunction

endpackage

// File: rtl/counter_4bit.sv
// Up/down binary counter with enable, synchronous load and registered terminal count.
// Define COUNTER_SATURATE_EN to clamp at all-ones/zero instead of wrapping.
module counter_4bit
    import counter_pkg::*;
#(
    parameter int               WIDTH   = DEFAULT_WIDTH,
    parameter logic [WIDTH-1:0] RST_VAL = '0
) (
    input  logic             iclk,
    input  logic             irst,
    input  logic             ien,
    input  logic             iup,
    input  logic             iload,
    input  logic [WIDTH-1:0] idata,
    output logic [WIDTH-1:0] ocnt,
    output logic             otc
);

`ifdef COUNTER_SATURATE_EN
    localparam logic SAT = 1'b1;
`else
    localparam logic SAT = 1'b0;
`endif

    dir_e             dir;
    logic [WIDTH-1:0] cnt_step;
    logic [WIDTH-1:0] cnt_nxt;
    logic             tc_nxt;

    assign dir = dir_e'(iup);

    always_comb begin
        cnt_step = WIDTH'(next_count(32'(ocnt), dir, SAT, WIDTH));
        cnt_nxt  = ocnt;
        tc_nxt   = otc;
        if (iload) begin
            cnt_nxt = idata;
        end else if (ien) begin
            cnt_nxt = cnt_step;
        end
        // otc only re-evaluates when the count is being updated; a pure hold keeps it.
        if (iload || ien) begin
            tc_nxt = (dir == DIR_UP) ? (cnt_nxt == '1) : (cnt_nxt == '0);
        end
    end

    always_ff @(posedge iclk or negedge irst) begin
        if (!irst) begin
            ocnt <= RST_VAL;
            otc  <= 1'b0;
        end else begin
            ocnt <= cnt_nxt;
            otc  <= tc_nxt;
        end
    end

endmodule

// File: tb/tb_counter_4bit.sv
// Scoreboard bench for counter_4bit: stimulus queues hand-computed expectations,
// a monitor pops them after each rising edge or asynchronous reset event.
module tb_counter_4bit;

    logic       iclk;
    logic       irst;
    logic       ien;
    logic       iup;
    logic       iload;
    logic [3:0] idata;
    logic [3:0] ocnt;
    logic       otc;

    typedef struct {
        string      name;
        logic [3:0] cnt;
        logic       tc;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;
    event async_ev;

    counter_4bit #(
        .WIDTH   (4),
        .RST_VAL (4'd0)
    ) dut (
        .iclk  (iclk),
        .irst  (irst),
        .ien   (ien),
        .iup   (iup),
        .iload (iload),
        .idata (idata),
        .ocnt  (ocnt),
        .otc   (otc)
    );

    initial iclk = 1'b0;
    always #10 iclk = ~iclk;

    task automatic push_exp(input string nm, input logic [3:0] ecnt, input logic etc);
        exp_t e;
        e.name = nm;
        e.cnt  = ecnt;
        e.tc   = etc;
        sb.push_back(e);
    endtask

    task automatic step(input logic en, input logic up, input logic ld, input logic [3:0] d,
                        input logic [3:0] ecnt, input logic etc, input string nm);
        @(negedge iclk);
        ien   = en;
        iup   = up;
        iload = ld;
        idata = d;
        push_exp(nm, ecnt, etc);
    endtask

    // Monitor
    initial begin
        exp_t e;
        forever begin
            @(posedge iclk or async_ev);
            #1;
            while (sb.size() > 0) begin
                e = sb.pop_front();
                checks++;
                if (ocnt !== e.cnt || otc !== e.tc) begin
                    errors++;
                    $display("FAIL %s: got ocnt=%0d otc=%0b, expected ocnt=%0d otc=%0b",
                             e.name, ocnt, otc, e.cnt, e.tc);
                end
            end
        end
    end

    // Stimulus
    initial begin
        irst  = 1'b1;
        ien   = 1'b1;
        iup   = 1'b1;
        iload = 1'b0;
        idata = 4'd0;

        // Asynchronous clear before any clock edge
        #2 irst = 1'b0;
        #1 push_exp("rst_async", 4'd0, 1'b0);
        ->async_ev;

        for (int i = 0; i < 4; i++) step(1'b1, 1'b1, 1'b0, 4'd0, 4'd0, 1'b0, "rst_hold");

        // Release on a falling edge; first count on the next rising edge
        @(negedge iclk);
        irst = 1'b1;
        push_exp("rst_release", 4'd1, 1'b0);

        for (int k = 2; k <= 95; k++)
            step(1'b1, 1'b1, 1'b0, 4'd0, 4'(k % 16), ((k % 16) == 15), "up_run");

        // Down and wrap through zero
        step(1'b0, 1'b0, 1'b1, 4'd2, 4'd2, 1'b0, "down_load2");
        step(1'b1, 1'b0, 1'b0, 4'd0, 4'd1, 1'b0, "down_1");
        step(1'b1, 1'b0, 1'b0, 4'd0, 4'd0, 1'b1, "down_0");
`ifdef COUNTER_SATURATE_EN
        step(1'b1, 1'b0, 1'b0, 4'd0, 4'd0, 1'b1, "down_sat_a");
        step(1'b1, 1'b0, 1'b0, 4'd0, 4'd0, 1'b1, "down_sat_b");
`else
        step(1'b1, 1'b0, 1'b0, 4'd0, 4'd15, 1'b0, "down_wrap15");
        step(1'b1, 1'b0, 1'b0, 4'd0, 4'd14, 1'b0, "down_14");
`endif

        // Load wins over count
        step(1'b0, 1'b1, 1'b1, 4'd7, 4'd7, 1'b0, "load7");
        step(1'b1, 1'b1, 1'b1, 4'd12, 4'd12, 1'b0, "load_prio");
        for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 1'b0, 4'd0, 4'd12, 1'b0, "hold12");

        // Loaded terminal values set otc; hold keeps otc even when iup flips
        step(1'b0, 1'b1, 1'b1, 4'd15, 4'd15, 1'b1, "load_tc_up");
        step(1'b0, 1'b0, 1'b0, 4'd0, 4'd15, 1'b1, "hold_tc_dirflip");
        step(1'b0, 1'b0, 1'b1, 4'd0, 4'd0, 1'b1, "load_tc_down");

        // Mid-operation reset pulse between edges
        step(1'b1, 1'b1, 1'b1, 4'd8, 4'd8, 1'b0, "pre_rst_load8");
        step(1'b1, 1'b1, 1'b0, 4'd0, 4'd9, 1'b0, "pre_rst_9");
        @(posedge iclk);
        #4 irst = 1'b0;
        #1 push_exp("rst_mid", 4'd0, 1'b0);
        ->async_ev;
        #4 irst = 1'b1;
        step(1'b1, 1'b1, 1'b0, 4'd0, 4'd1, 1'b0, "rst_resume");

        // Top-end wrap vs saturation
        step(1'b1, 1'b1, 1'b1, 4'd14, 4'd14, 1'b0, "load14");
`ifdef COUNTER_SATURATE_EN
        for (int i = 0; i < 4; i++) step(1'b1, 1'b1, 1'b0, 4'd0, 4'd15, 1'b1, "up_sat");
`else
        step(1'b1, 1'b1, 1'b0, 4'd0, 4'd15, 1'b1, "up_15");
        step(1'b1, 1'b1, 1'b0, 4'd0, 4'd0, 1'b0, "up_wrap0");
        step(1'b1, 1'b1, 1'b0, 4'd0, 4'd1, 1'b0, "up_1");
        step(1'b1, 1'b1, 1'b0, 4'd0, 4'd2, 1'b0, "up_2");
`endif

        @(posedge iclk);
        #3;
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d expectations left, expected 0", sb.size());
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
